// File: rtl/dct_var_engine.sv
// Handshaked 1-D DCT-II engine for 4/8/16-point transforms, one coefficient per cycle.
// Samples are latched on acceptance, then coefficients are computed, rounded and saturated lane by lane.
module dct_var_engine #(
  parameter int IW   = 16,
  parameter int OW   = 16,
  parameter int CW   = 12,
  parameter int NMAX = 16,
  parameter int LW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NMAX*IW-1:0]   in_data,
  input  logic [LW-1:0]        in_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NMAX*OW-1:0]   out_data,
  output logic [1:0]           out_size,
  output logic                 busy
);
  localparam int PW = IW + CW + 1;
  localparam int AW = IW + CW + 5;
  localparam int MAXV = (2 ** (OW - 1)) - 1;
  localparam int MINV = -(2 ** (OW - 1));
  localparam logic signed [AW-1:0] SMAX = AW'(MAXV);
  localparam logic signed [AW-1:0] SMIN = AW'(MINV);
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (CW - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t state_r, state_s;
  logic signed [IW-1:0] x_r [NMAX];
  logic signed [IW-1:0] x_s [NMAX];
  logic [1:0]           size_r, size_s, size_in_s;
  logic [3:0]           k_r, k_s, last_k_s;
  logic [NMAX*OW-1:0]   data_r, data_s;
  logic                 valid_r, valid_s, ready_r, ready_s, busy_r, busy_s;
  logic signed [PW-1:0] prod_s;
  logic signed [AW-1:0] acc_s, shr_s;
  logic signed [OW-1:0] xk_s;

  // Folded coefficient table for CW=12: the angle (2n+1)k*pi/(2N) is mapped to j*pi/32, 0<=j<=16, plus a sign.
  function automatic logic signed [CW:0] coef(input logic [1:0] sz, input logic [3:0] k, input logic [3:0] n);
    logic [9:0]    prod;
    logic [5:0]    m;
    logic [4:0]    j;
    logic          neg;
    logic [CW-1:0] mag;
    prod = 10'({n, 1'b1}) * 10'(k);
    case (sz)
      2'd0:    m = {prod[3:0], 2'b00};
      2'd1:    m = {prod[4:0], 1'b0};
      default: m = prod[5:0];
    endcase
    if (m > 6'd32) m = 6'd0 - m;
    else           m = m;
    if (m > 6'd16) begin
      j   = 5'(6'd32 - m);
      neg = 1'b1;
    end else begin
      j   = m[4:0];
      neg = 1'b0;
    end
    if (k == 4'd0) begin
      case (sz)
        2'd0:    mag = 12'd2048;
        2'd1:    mag = 12'd1448;
        default: mag = 12'd1024;
      endcase
    end else begin
      case (sz)
        2'd0: begin
          case (j)
            5'd0:    mag = 12'd2896;
            5'd4:    mag = 12'd2676;
            5'd8:    mag = 12'd2048;
            5'd12:   mag = 12'd1108;
            default: mag = 12'd0;
          endcase
        end
        2'd1: begin
          case (j)
            5'd0:    mag = 12'd2048;
            5'd2:    mag = 12'd2009;
            5'd4:    mag = 12'd1892;
            5'd6:    mag = 12'd1703;
            5'd8:    mag = 12'd1448;
            5'd10:   mag = 12'd1138;
            5'd12:   mag = 12'd784;
            5'd14:   mag = 12'd400;
            default: mag = 12'd0;
          endcase
        end
        default: begin
          case (j)
            5'd0:    mag = 12'd1448;
            5'd1:    mag = 12'd1441;
            5'd2:    mag = 12'd1420;
            5'd3:    mag = 12'd1386;
            5'd4:    mag = 12'd1338;
            5'd5:    mag = 12'd1277;
            5'd6:    mag = 12'd1204;
            5'd7:    mag = 12'd1119;
            5'd8:    mag = 12'd1024;
            5'd9:    mag = 12'd919;
            5'd10:   mag = 12'd805;
            5'd11:   mag = 12'd683;
            5'd12:   mag = 12'd554;
            5'd13:   mag = 12'd420;
            5'd14:   mag = 12'd283;
            5'd15:   mag = 12'd142;
            default: mag = 12'd0;
          endcase
        end
      endcase
    end
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // Multiplier bank, adder tree, round-half-up and saturation for coefficient k_r.
  always_comb begin
    acc_s  = '0;
    prod_s = '0;
    for (int n = 0; n < NMAX; n++) begin
      prod_s = x_r[n] * coef(size_r, k_r, 4'(n));
      acc_s  = acc_s + {{(AW-PW){prod_s[PW-1]}}, prod_s};
    end
    shr_s = (acc_s + HALF) >>> CW;
    if (shr_s > SMAX)      xk_s = OW'(MAXV);
    else if (shr_s < SMIN) xk_s = OW'(MINV);
    else                   xk_s = shr_s[OW-1:0];
  end

  // Transform size from the requested sample count, and last coefficient index of the active size.
  always_comb begin
    if (in_len <= LW'(4))      size_in_s = 2'd0;
    else if (in_len <= LW'(8)) size_in_s = 2'd1;
    else                       size_in_s = 2'd2;
    case (size_r)
      2'd0:    last_k_s = 4'd3;
      2'd1:    last_k_s = 4'd7;
      default: last_k_s = 4'd15;
    endcase
  end

  // Next-state and next-output logic of the request FSM.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    size_s  = size_r;
    k_s     = k_r;
    data_s  = data_r;
    valid_s = valid_r;
    ready_s = ready_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          for (int n = 0; n < NMAX; n++) begin
            x_s[n] = (in_len > LW'(n)) ? $signed(in_data[n*IW +: IW]) : '0;
          end
          size_s  = size_in_s;
          data_s  = '0;
          k_s     = 4'd0;
          ready_s = 1'b0;
          busy_s  = 1'b1;
          state_s = CALC;
        end else begin
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
      end
      CALC: begin
        data_s[k_r*OW +: OW] = xk_s;
        if (k_r == last_k_s) begin
          valid_s = 1'b1;
          state_s = DONE;
        end else begin
          k_s = k_r + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_s = 1'b0;
          ready_s = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        valid_s = 1'b0;
        ready_s = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, sample and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      for (int n = 0; n < NMAX; n++) x_r[n] <= '0;
      size_r  <= 2'd0;
      k_r     <= 4'd0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      size_r  <= size_s;
      k_r     <= k_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_size  = size_r;
  assign busy      = busy_r;
endmodule

// File: tb/tb_dct_var_engine.sv
// Bench for dct_var_engine: directed vector table, randomized requests against a real-valued DCT-II model,
// plus backpressure and mid-transform reset sequences.
module tb_dct_var_engine;
  localparam int IW = 16, OW = 16, CW = 12, NMAX = 16, LW = 5;
  localparam real PI = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NMAX*IW-1:0]  in_data = '0;
  logic [LW-1:0]       in_len = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [NMAX*OW-1:0]  out_data;
  logic [1:0]          out_size;
  logic                busy;

  int n_checks = 0;
  int n_fail = 0;
  int xs [NMAX];
  int cur_len;
  int exp_lane [NMAX];
  int exp_size;
  int exp_n;

  typedef struct {
    string name;
    int    len;
    int    fill;
    int    x0;
    int    exp_size;
    int    exp_lane0;
  } vec_t;
  vec_t vecs [7];

  dct_var_engine #(.IW(IW), .OW(OW), .CW(CW), .NMAX(NMAX), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_size(out_size), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mcoef(input int nn, input int k, input int n);
    real s, v;
    s = (k == 0) ? $sqrt(1.0 / nn) : $sqrt(2.0 / nn);
    v = 4096.0 * s * $cos(PI * (2 * n + 1) * k / (2.0 * nn));
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  function automatic int lane(input int k);
    logic signed [OW-1:0] t;
    t = out_data[k*OW +: OW];
    return int'(t);
  endfunction

  task automatic model();
    int len;
    longint acc, r;
    len = (cur_len > 16) ? 16 : cur_len;
    exp_n    = (len <= 4) ? 4 : (len <= 8) ? 8 : 16;
    exp_size = (exp_n == 4) ? 0 : (exp_n == 8) ? 1 : 2;
    for (int k = 0; k < NMAX; k++) begin
      exp_lane[k] = 0;
      if (k < exp_n) begin
        acc = 0;
        for (int n = 0; n < exp_n; n++)
          if (n < len) acc += longint'(xs[n]) * longint'(mcoef(exp_n, k, n));
        r = (acc + 2048) >>> 12;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        exp_lane[k] = int'(r);
      end
    end
  endtask

  task automatic start_req();
    @(negedge clk);
    for (int n = 0; n < NMAX; n++) in_data[n*IW +: IW] = 16'(xs[n]);
    in_len   = LW'(cur_len);
    in_valid = 1'b1;
    check("in_ready_before_accept", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_latency"}, cnt, exp_n);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_out_size"}, out_size, exp_size);
    for (int k = 0; k < NMAX; k++)
      check($sformatf("%s_lane%0d", tag, k), lane(k), exp_lane[k]);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, in_ready, 1);
    check({tag, "_idle_valid"}, out_valid, 0);
  endtask

  task automatic run_req(input string tag);
    model();
    start_req();
    wait_done(tag);
    check_result(tag);
    release_out(tag);
  endtask

  initial begin
    int stable_bad;
    logic [NMAX*OW-1:0] held;

    vecs[0] = '{"dc",       8,    100,    100,    1, 283};
    vecs[1] = '{"impulse",  16,   0,      4096,   2, 1024};
    vecs[2] = '{"sat_pos",  16,   32767,  32767,  2, 32767};
    vecs[3] = '{"sat_neg",  16,   -32768, -32768, 2, -32768};
    vecs[4] = '{"pad_len5", 5,    777,    777,    1, 1373};
    vecs[5] = '{"len0",     0,    50,     50,     0, 0};
    vecs[6] = '{"len20",    20,   10,     10,     2, 40};

    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data_zero", longint'(out_data == '0), 1);
    check("reset_out_size", out_size, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int n = 0; n < NMAX; n++) xs[n] = vecs[v].fill;
      xs[0]   = vecs[v].x0;
      cur_len = vecs[v].len;
      model();
      start_req();
      check({vecs[v].name, "_busy"}, busy, 1);
      wait_done(vecs[v].name);
      check({vecs[v].name, "_size_tbl"}, out_size, vecs[v].exp_size);
      check({vecs[v].name, "_lane0_tbl"}, lane(0), vecs[v].exp_lane0);
      check_result(vecs[v].name);
      release_out(vecs[v].name);
    end

    for (int t = 0; t < 24; t++) begin
      cur_len = int'($urandom_range(0, 31));
      for (int n = 0; n < NMAX; n++) begin
        if (t % 3 == 0) xs[n] = int'($urandom_range(0, 2000)) - 1000;
        else            xs[n] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_req($sformatf("rand%0d", t));
    end

    // Backpressure: hold the result, offer a competing request, then release into a back-to-back request.
    cur_len = 8;
    for (int n = 0; n < NMAX; n++) xs[n] = int'($urandom_range(0, 65535)) - 32768;
    model();
    start_req();
    wait_done("bp");
    held = out_data;
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_len   = 5'd16;
      in_data  = {NMAX{16'h1234}};
      @(posedge clk);
      #1;
      if (out_data != held || !out_valid || in_ready || !busy) stable_bad++;
    end
    in_valid = 1'b0;
    check("bp_hold_stable", stable_bad, 0);
    check_result("bp_hold");
    release_out("bp");
    cur_len = 16;
    for (int n = 0; n < NMAX; n++) xs[n] = int'($urandom_range(0, 65535)) - 32768;
    run_req("bp_next");

    // Reset three cycles into a 16-point transform.
    cur_len = 16;
    for (int n = 0; n < NMAX; n++) xs[n] = 1000 + n;
    model();
    start_req();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_out_data_zero", longint'(out_data == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    stable_bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) stable_bad++;
    end
    check("rst_no_valid_pulse", stable_bad, 0);
    for (int n = 0; n < NMAX; n++) xs[n] = int'($urandom_range(0, 65535)) - 32768;
    run_req("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
